// File: rtl/multicycle_control.sv
// multicycle_control
//   Moore FSM controller for the multi-cycle MIPS datapath. It sequences the
//   shared memory port, ALU, IR, PC and register file over 3-5 states per
//   instruction. It waits on a memory ready handshake, with an optional
//   timeout, and counts retired instructions.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   opcode[5:0]         : IR[31:26], sampled in DECODE only
//   mem_ready           : memory completed the current access this cycle
//   pc_write, pc_write_cond, pc_source[1:0]        : PC update controls
//   i_or_d, mem_read, mem_write, ir_write          : memory / IR controls
//   reg_dst, mem_to_reg, reg_write                 : register file controls
//   alu_src_a, alu_src_b[1:0], alu_op[1:0]         : ALU operand / op select
//   instr_done, illegal_op, mem_err                : one-cycle status pulses
//   retired_count[CNT_W-1:0]                       : retired instruction count
//   state[3:0]                                     : current state (debug)
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             instr_done,
  output logic             illegal_op,
  output logic             mem_err,
  output logic [CNT_W-1:0] retired_count,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_RIMM  = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam int              WC_W   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_MAX = WC_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t            state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic              timeout;
  logic              illegal;
  logic              done;

  // Next-state, wait counter and retirement.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wait_cnt_d = '0;
    timeout    = 1'b0;
    illegal    = 1'b0;
    done       = 1'b0;

    // wait_cnt only advances while stalled in a memory state; every state
    // change happens with mem_ready high or on a timeout, so it clears then.
    if ((state_q == S_FETCH || state_q == S_MEM_RD || state_q == S_MEM_WR) && !mem_ready) begin
      if (MEM_TIMEOUT != 0 && wait_cnt_q == WC_MAX) begin
        timeout = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end

    case (state_q)
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_FETCH;
      end
      S_DECODE: begin
        op_d = opcode;
        case (opcode)
          OP_LW, OP_SW:      state_d = S_MEM_ADDR;
          OP_RTYPE, OP_RIMM: state_d = S_R_EXEC;
          OP_ADDI, OP_ANDI:  state_d = S_I_EXEC;
          OP_BEQ:            state_d = S_BRANCH;
          OP_J:              state_d = S_JUMP;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready)    state_d = S_MEM_WB;
        else if (timeout) state_d = S_FETCH;
      end
      S_MEM_WB: begin
        state_d = S_FETCH;
        done    = 1'b1;
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          done    = 1'b1;
        end else if (timeout) begin
          state_d = S_FETCH;
        end
      end
      S_R_EXEC: state_d = S_R_WB;
      S_I_EXEC: state_d = S_I_WB;
      S_R_WB, S_I_WB, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        done    = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    retired_d = retired_q + CNT_W'(done);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      op_q       <= '0;
      wait_cnt_q <= '0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      wait_cnt_q <= wait_cnt_d;
      retired_q  <= retired_d;
    end
  end

  // Control decode. Reset gates everything combinationally so a reset
  // arriving mid-instruction cancels any in-flight write that same cycle.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;

    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE:   alu_src_b = 2'b11;
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
          alu_src_b = (op_q == OP_RIMM) ? 2'b10 : 2'b00;
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_I_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = (op_q == OP_ANDI) ? 2'b11 : 2'b00;
        end
        S_I_WB:   reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign instr_done    = done    && !reset;
  assign illegal_op    = illegal && !reset;
  assign mem_err       = timeout && !reset;
  assign state         = reset ? 4'd0 : state_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control. Inputs change 1 time unit after
// the rising edge; outputs are checked on the falling edge.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]  pc_source, alu_src_b, alu_op;
  logic        instr_done, illegal_op, mem_err;
  logic [31:0] retired_count;
  logic [3:0]  state;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  multicycle_control #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .instr_done(instr_done), .illegal_op(illegal_op),
    .mem_err(mem_err), .retired_count(retired_count), .state(state)
  );

  always #5 clk = ~clk;

  // {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
  //  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op}
  logic [15:0] ctrl;
  assign ctrl = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                 ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op};

  localparam logic [15:0] C_NONE    = 16'h0000;
  localparam logic [15:0] C_FETCH_R = 16'h8504;
  localparam logic [15:0] C_FETCH_W = 16'h0404;
  localparam logic [15:0] C_DECODE  = 16'h000C;
  localparam logic [15:0] C_MADDR   = 16'h0018;
  localparam logic [15:0] C_MRD     = 16'h0C00;
  localparam logic [15:0] C_MWB     = 16'h0060;
  localparam logic [15:0] C_MWR     = 16'h0A00;
  localparam logic [15:0] C_REXEC   = 16'h0012;
  localparam logic [15:0] C_REXEC_I = 16'h001A;
  localparam logic [15:0] C_RWB     = 16'h00A0;
  localparam logic [15:0] C_ADDI    = 16'h0018;
  localparam logic [15:0] C_ANDI    = 16'h001B;
  localparam logic [15:0] C_IWB     = 16'h0020;
  localparam logic [15:0] C_BRANCH  = 16'h5011;
  localparam logic [15:0] C_JUMP    = 16'hA000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // One clock cycle: check state, control vector and pulses, then advance.
  task automatic cyc(input string tag, input logic [3:0] es, input logic [15:0] ec,
                     input logic ed, input logic ei, input logic ee);
    @(negedge clk);
    check({tag, ".state"}, 32'(state), 32'(es));
    check({tag, ".ctrl"}, 32'(ctrl), 32'(ec));
    check({tag, ".done"}, 32'(instr_done), 32'(ed));
    check({tag, ".illegal"}, 32'(illegal_op), 32'(ei));
    check({tag, ".memerr"}, 32'(mem_err), 32'(ee));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; opcode = 6'd0; mem_ready = 1'b1;
    // 1: reset held 3 cycles, then FETCH.
    for (int unsigned i = 0; i < 3; i++) cyc("rst", 4'd0, C_NONE, 0, 0, 0);
    check("rst.count", retired_count, 32'd0);
    reset = 1'b0;
    // 2: instruction stream with mem_ready = 1.
    cyc("add.f", 4'd0, C_FETCH_R, 0, 0, 0);
    opcode = 6'b000000; cyc("add.d", 4'd1, C_DECODE, 0, 0, 0);
    opcode = 6'b111111; cyc("add.x", 4'd6, C_REXEC, 0, 0, 0);
    cyc("add.wb", 4'd7, C_RWB, 1, 0, 0);
    cyc("lw.f", 4'd0, C_FETCH_R, 0, 0, 0);
    opcode = 6'b100011; cyc("lw.d", 4'd1, C_DECODE, 0, 0, 0);
    opcode = 6'b101011; cyc("lw.a", 4'd2, C_MADDR, 0, 0, 0);
    cyc("lw.rd", 4'd3, C_MRD, 0, 0, 0);
    cyc("lw.wb", 4'd4, C_MWB, 1, 0, 0);
    cyc("sw.f", 4'd0, C_FETCH_R, 0, 0, 0);
    cyc("sw.d", 4'd1, C_DECODE, 0, 0, 0);
    cyc("sw.a", 4'd2, C_MADDR, 0, 0, 0);
    cyc("sw.wr", 4'd5, C_MWR, 1, 0, 0);
    cyc("beq.f", 4'd0, C_FETCH_R, 0, 0, 0);
    opcode = 6'b000100; cyc("beq.d", 4'd1, C_DECODE, 0, 0, 0);
    cyc("beq.b", 4'd10, C_BRANCH, 1, 0, 0);
    cyc("j.f", 4'd0, C_FETCH_R, 0, 0, 0);
    opcode = 6'b000010; cyc("j.d", 4'd1, C_DECODE, 0, 0, 0);
    cyc("j.j", 4'd11, C_JUMP, 1, 0, 0);
    cyc("andi.f", 4'd0, C_FETCH_R, 0, 0, 0);
    opcode = 6'b001100; cyc("andi.d", 4'd1, C_DECODE, 0, 0, 0);
    opcode = 6'b001000; cyc("andi.x", 4'd8, C_ANDI, 0, 0, 0);
    cyc("andi.wb", 4'd9, C_IWB, 1, 0, 0);
    check("stream.count", retired_count, 32'd6);
    cyc("rimm.f", 4'd0, C_FETCH_R, 0, 0, 0);
    opcode = 6'b110000; cyc("rimm.d", 4'd1, C_DECODE, 0, 0, 0);
    opcode = 6'b000000; cyc("rimm.x", 4'd6, C_REXEC_I, 0, 0, 0);
    cyc("rimm.wb", 4'd7, C_RWB, 1, 0, 0);
    cyc("addi.f", 4'd0, C_FETCH_R, 0, 0, 0);
    opcode = 6'b001000; cyc("addi.d", 4'd1, C_DECODE, 0, 0, 0);
    opcode = 6'b001100; cyc("addi.x", 4'd8, C_ADDI, 0, 0, 0);
    cyc("addi.wb", 4'd9, C_IWB, 1, 0, 0);
    check("imm.count", retired_count, 32'd8);
    // 3: lw with three memory wait cycles.
    cyc("lww.f", 4'd0, C_FETCH_R, 0, 0, 0);
    opcode = 6'b100011; cyc("lww.d", 4'd1, C_DECODE, 0, 0, 0);
    cyc("lww.a", 4'd2, C_MADDR, 0, 0, 0);
    mem_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) cyc("lww.wait", 4'd3, C_MRD, 0, 0, 0);
    mem_ready = 1'b1; cyc("lww.rd", 4'd3, C_MRD, 0, 0, 0);
    cyc("lww.wb", 4'd4, C_MWB, 1, 0, 0);
    check("lww.count", retired_count, 32'd9);
    // 4: FETCH timeout on the 16th wait cycle, then ready on exactly the 16th.
    mem_ready = 1'b0;
    for (int unsigned i = 0; i < 15; i++) cyc("to.wait", 4'd0, C_FETCH_W, 0, 0, 0);
    cyc("to.err", 4'd0, C_FETCH_W, 0, 0, 1);
    for (int unsigned i = 0; i < 15; i++) cyc("to2.wait", 4'd0, C_FETCH_W, 0, 0, 0);
    mem_ready = 1'b1; cyc("to2.ready", 4'd0, C_FETCH_R, 0, 0, 0);
    // 5: illegal opcode in DECODE.
    opcode = 6'b111111; cyc("ill.d", 4'd1, C_DECODE, 0, 1, 0);
    check("ill.count", retired_count, 32'd9);
    // 6: reset while MEM_WR waits.
    cyc("rsw.f", 4'd0, C_FETCH_R, 0, 0, 0);
    opcode = 6'b101011; cyc("rsw.d", 4'd1, C_DECODE, 0, 0, 0);
    cyc("rsw.a", 4'd2, C_MADDR, 0, 0, 0);
    mem_ready = 1'b0; cyc("rsw.wr", 4'd5, C_MWR, 0, 0, 0);
    reset = 1'b1; cyc("rsw.rst", 4'd0, C_NONE, 0, 0, 0);
    check("rsw.count", retired_count, 32'd0);
    reset = 1'b0; cyc("rsw.after", 4'd0, C_FETCH_W, 0, 0, 0);
    check("rsw.count2", retired_count, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore FSM controller for the multi-cycle MIPS datapath variant.
- Replaces the single-cycle opcode decode.
- Sequences one shared memory port, a single ALU, the IR, the PC and the register file across 3–5 states per instruction.
- Handles a memory ready handshake with a timeout, and keeps a retired-instruction count.

Parameters:
- MEM_TIMEOUT, 16: number of consecutive cycles a memory state may wait for mem_ready before aborting; 0 disables the timeout.
- CNT_W, 32: width of retired_count.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26]; valid from the DECODE state onward.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- pc_write  out  1  PC load enable (unconditional).
- pc_write_cond  out  1  PC load enable, qualified by the ALU zero flag outside this block.
- pc_source  out  2  PC mux select: 00 = ALU result, 01 = ALUOut register, 10 = jump target.
- i_or_d  out  1  memory address mux select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load enable.
- reg_dst  out  1  destination register select: 1 = rd, 0 = rt.
- mem_to_reg  out  1  write-back data select: 1 = MDR, 0 = ALUOut.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- alu_op  out  2  to the ALU control unit: 00 = add, 01 = sub, 10 = funct field, 11 = and.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal_op  out  1  one-cycle pulse when an unknown opcode is decoded.
- mem_err  out  1  one-cycle pulse when a memory wait times out.
- retired_count  out  CNT_W  count of retired instructions.
- state  out  4  current state code, for debug.

Behaviour:
- State codes: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, I_EXEC=8, I_WB=9, BRANCH=10, JUMP=11.
- Reset:
  - state goes to FETCH; op_q, wait_cnt and retired_count clear to 0.
  - While reset is high, every control output, pulse output and state output is forced to 0.
  - A reset asserted mid-instruction abandons that instruction. No write is issued after the reset edge.
- Control outputs are 0 in every state unless listed below.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write equal mem_ready.
  - Goes to DECODE when mem_ready is high; otherwise waits.
- DECODE:
  - op_q <= opcode.
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes the branch target).
  - Next state by opcode:
    - 100011 (lw) or 101011 (sw) -> MEM_ADDR
    - 000000 or 110000 -> R_EXEC
    - 001000 (addi) or 001100 (andi) -> I_EXEC
    - 000100 (beq) -> BRANCH
    - 000010 (j) -> JUMP
    - any other opcode -> FETCH with illegal_op pulsed
- MEM_ADDR:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next state: MEM_RD if op_q is lw, otherwise MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1; goes to MEM_WB when mem_ready is high.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; goes to FETCH.
- MEM_WR: mem_write=1, i_or_d=1; goes to FETCH when mem_ready is high.
- R_EXEC:
  - Outputs: alu_src_a=1, alu_op=10.
  - alu_src_b=10 if op_q is 110000, otherwise 00.
  - Goes to R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; goes to FETCH.
- I_EXEC:
  - Outputs: alu_src_a=1, alu_src_b=10.
  - alu_op=00 for addi, 11 for andi.
  - Goes to I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0; goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; goes to FETCH.
- JUMP: pc_write=1, pc_source=10; goes to FETCH.
- Retirement:
  - instr_done is high for the single cycle in which the FSM leaves MEM_WB, R_WB, I_WB, BRANCH or JUMP, or leaves MEM_WR with mem_ready high.
  - retired_count increments by 1 on that same edge and wraps modulo 2^CNT_W.
  - Illegal opcodes, timeouts and resets do not retire an instruction.
- Latency: lw 5 cycles; sw 4; R-type, addi and andi 4; beq and j 3. Each memory state adds its wait cycles to these figures.
- Timeout:
  - wait_cnt counts cycles spent in FETCH, MEM_RD or MEM_WR with mem_ready low.
  - It clears on any state change and on every cycle mem_ready is high.
  - If MEM_TIMEOUT is nonzero and wait_cnt equals MEM_TIMEOUT-1 with mem_ready still low:
    - mem_err pulses for that cycle;
    - the next state is FETCH;
    - wait_cnt clears;
    - no write enable is asserted.
  - If mem_ready is high in the same cycle as the timeout condition, mem_ready wins: normal advance and no mem_err.
- opcode is sampled only in DECODE. Changes to opcode in later states do not affect sequencing.

Test Plan:
1. Reset held 3 cycles then released; mem_ready tied to 1 -> all outputs 0 while reset is high; state=0 after release; FETCH asserts mem_read=1, alu_src_b=01, ir_write=1 and pc_write=1 in the same cycle.
2. Stream add(000000), lw, sw, beq, j, andi with mem_ready=1 -> state sequences 0,1,6,7 / 0,1,2,3,4 / 0,1,2,5 / 0,1,10 / 0,1,11 / 0,1,8,9, each followed by a return to 0; exact control vectors per state as specified; retired_count=6.
3. lw with mem_ready held low for 3 cycles in MEM_RD -> MEM_RD held for 4 cycles with mem_read=1 and i_or_d=1; reg_write not asserted until MEM_WB.
4. MEM_TIMEOUT=16 with mem_ready stuck at 0 in FETCH -> mem_err pulses on the 16th wait cycle; state stays 0; instr_done is never asserted. Repeat with mem_ready rising on exactly the 16th cycle -> no mem_err and the FSM advances to DECODE.
5. Opcode 111111 -> illegal_op pulses in DECODE; next state is 0; retired_count unchanged.
6. Reset asserted in MEM_WR while mem_ready is low -> mem_write drops to 0 that cycle; state=0 after release; retired_count=0.
